// File: rtl/oric_ram_pkg.sv
// rtl/oric_ram_pkg.sv - shared state, request type and fill default for the RAM/tape-loader arbiter
package oric_ram_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} ram_state_t;

    // Widest address/data a loader request can carry; narrower builds zero-extend.
    localparam int WR_AW = 16;
    localparam int WR_DW = 8;

    // Fill bit, replicated across the data width to form the clear pattern.
    localparam logic DEF_FILL = 1'b1;

    typedef struct packed {
        logic [WR_AW-1:0] addr;
        logic [WR_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/oric_ram_loader_arb_if.sv
// rtl/oric_ram_loader_arb_if.sv - CPU and tape-loader bus bundle for the RAM arbiter
interface oric_ram_loader_arb_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [AW-1:0] cpu_ad;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic          cpu_cs;
    logic [DW-1:0] cpu_q;
    logic [AW-1:0] tape_addr;
    logic [DW-1:0] tape_dout;
    logic          tape_wr;
    logic          tape_complete;
    logic          tape_wait;
    logic          clr_busy;
    logic          load_done;
    logic [DW-1:0] tape_csum;

    modport master (
        output cpu_ad, cpu_din, cpu_we, cpu_cs,
        output tape_addr, tape_dout, tape_wr, tape_complete,
        input  cpu_q, tape_wait, clr_busy, load_done, tape_csum
    );

    modport slave (
        input  cpu_ad, cpu_din, cpu_we, cpu_cs,
        input  tape_addr, tape_dout, tape_wr, tape_complete,
        output cpu_q, tape_wait, clr_busy, load_done, tape_csum
    );
endinterface

// File: rtl/oric_wr_fifo.sv
// rtl/oric_wr_fifo.sv - synchronous FIFO of loader write requests
module oric_wr_fifo
    import oric_ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 8
) (
    input  logic    clk_48,
    input  logic    reset,
    input  logic    push,
    input  wr_req_t push_req,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wr_req_t head
);
    localparam int PW = $clog2(DEPTH);

    // Only the significant AW/DW bits are stored.
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;
    logic          unused_req;

    assign unused_req = ^push_req;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_48) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_48) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_req.addr[AW-1:0];
            mem_data[wr_ptr] <= push_req.data[DW-1:0];
        end
    end

    assign head = '{addr: WR_AW'(mem_addr[rd_ptr]), data: WR_DW'(mem_data[rd_ptr])};

endmodule

// File: rtl/oric_ram_loader_arb.sv
// rtl/oric_ram_loader_arb.sv - RAM with post-reset clear sweep and FIFO-buffered tape-loader port
// Optional checksum of committed loader bytes enabled by macro ORIC_TAPE_CSUM_EN.
module oric_ram_loader_arb
    import oric_ram_pkg::*;
#(
    parameter int            AW         = 16,
    parameter int            DW         = 8,
    parameter logic [DW-1:0] FILL       = {DW{DEF_FILL}},
    parameter int            FIFO_DEPTH = 4
) (
    input  logic clk_48,
    input  logic reset,
    oric_ram_loader_arb_if.slave bus
);
    logic [DW-1:0] ram [2**AW];

    ram_state_t    state;
    ram_state_t    state_next;
    logic [AW-1:0] clr_cnt;

    logic          cpu_wr;
    logic          pop;
    logic          push;
    logic          full;
    logic          empty;
    wr_req_t       push_req;
    wr_req_t       head;
    logic          unused_head;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    logic [DW-1:0] q_r;
    logic          complete_seen;
    logic          load_done_r;

    assign unused_head = ^head;

    assign cpu_wr        = bus.cpu_cs & bus.cpu_we;
    // CPU owns the write port; the FIFO head only commits on CPU-idle RUN cycles.
    assign pop           = (state == ST_RUN) & ~cpu_wr & ~empty;
    assign bus.tape_wait = full & ~pop;
    assign push          = bus.tape_wr & ~bus.tape_wait;
    assign push_req      = '{addr: WR_AW'(bus.tape_addr), data: WR_DW'(bus.tape_dout)};

    oric_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk_48   (clk_48),
        .reset    (reset),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_ff @(posedge clk_48) begin
        if (reset) state <= ST_CLEAR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_cnt == '1) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_48) begin
        if (reset)                  clr_cnt <= '0;
        else if (state == ST_CLEAR) clr_cnt <= clr_cnt + AW'(1);
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = clr_cnt;
        ram_wdata = FILL;
        if (reset) begin
            ram_we = 1'b0;
        end else if (state == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (cpu_wr) begin
            ram_we    = 1'b1;
            ram_addr  = bus.cpu_ad;
            ram_wdata = bus.cpu_din;
        end else if (pop) begin
            ram_we    = 1'b1;
            ram_addr  = head.addr[AW-1:0];
            ram_wdata = head.data[DW-1:0];
        end
    end

    always_ff @(posedge clk_48) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    // Read before write: a same-cycle write is visible only on the following read.
    always_ff @(posedge clk_48) begin
        if (reset)                  q_r <= '0;
        else if (state == ST_CLEAR) q_r <= FILL;
        else                        q_r <= ram[bus.cpu_ad];
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            complete_seen <= 1'b0;
            load_done_r   <= 1'b0;
        end else begin
            complete_seen <= complete_seen | bus.tape_complete;
            if ((state == ST_RUN) && complete_seen && empty) load_done_r <= 1'b1;
        end
    end

`ifdef ORIC_TAPE_CSUM_EN
    logic [DW-1:0] csum_r;

    always_ff @(posedge clk_48) begin
        if (reset)    csum_r <= '0;
        else if (pop) csum_r <= csum_r + head.data[DW-1:0];
    end

    assign bus.tape_csum = csum_r;
`else
    assign bus.tape_csum = '0;
`endif

    assign bus.cpu_q     = q_r;
    assign bus.clr_busy  = (state == ST_CLEAR);
    assign bus.load_done = load_done_r;

endmodule

// File: tb/tb_oric_ram_loader_arb.sv
// tb/tb_oric_ram_loader_arb.sv - directed scoreboard bench for oric_ram_loader_arb (AW=8, FIFO_DEPTH=4)
module tb_oric_ram_loader_arb;
    import oric_ram_pkg::*;

`ifdef ORIC_TAPE_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk_48;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] exp_mem [256];
    logic [7:0] sb [$];

    oric_ram_loader_arb_if #(.AW(8), .DW(8)) bus ();

    oric_ram_loader_arb #(.AW(8), .DW(8), .FIFO_DEPTH(4)) dut (
        .clk_48 (clk_48),
        .reset  (reset),
        .bus    (bus)
    );

    initial begin
        clk_48 = 1'b0;
        forever #5 clk_48 = ~clk_48;
    end

    // Loader must never strobe while the FIFO reports full.
    always @(posedge clk_48) begin
        if (!reset && bus.tape_wr && bus.tape_wait) begin
            failures++;
            $error("FAIL tape_protocol: observed tape_wr=1 with tape_wait=1, required tape_wr=0");
        end
    end

    task automatic step();
        @(posedge clk_48);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_cs(input logic [7:0] v);
        return CSUM_ON ? v : 8'h00;
    endfunction

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        bus.cpu_ad = a;
        bus.cpu_cs = 1'b1;
        bus.cpu_we = 1'b0;
        sb.push_back(e);
        step();
        chk($sformatf("rd_%02h", a), bus.cpu_q, sb.pop_front());
        bus.cpu_cs = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.cpu_ad  = a;
        bus.cpu_din = d;
        bus.cpu_cs  = 1'b1;
        bus.cpu_we  = 1'b1;
        step();
        bus.cpu_cs  = 1'b0;
        bus.cpu_we  = 1'b0;
        exp_mem[a]  = d;
    endtask

    task automatic push_byte(input logic [7:0] a, input logic [7:0] d);
        bus.tape_addr = a;
        bus.tape_dout = d;
        bus.tape_wr   = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.cpu_ad        = '0;
        bus.cpu_din       = '0;
        bus.cpu_we        = 1'b0;
        bus.cpu_cs        = 1'b0;
        bus.tape_addr     = '0;
        bus.tape_dout     = '0;
        bus.tape_wr       = 1'b0;
        bus.tape_complete = 1'b0;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_cpu_q"}, bus.cpu_q, 8'h00);
        chk({tag, "_tape_wait"}, bus.tape_wait, 1'b0);
        chk({tag, "_clr_busy"}, bus.clr_busy, 1'b1);
        chk({tag, "_load_done"}, bus.load_done, 1'b0);
        chk({tag, "_csum"}, bus.tape_csum, 8'h00);
    endtask

    task automatic wait_sweep(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.clr_busy && n < 400);
        chk(tag, n, 256);
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;

        // 1: reset, 256-cycle sweep with ignored CPU write, then every location is FILL
        step();
        reset_values("t1_reset");
        reset = 1'b0;
        n = 0;
        do begin
            if (n == 100) begin
                bus.cpu_ad = 8'h40; bus.cpu_din = 8'h00; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
            end else begin
                bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
            end
            step();
            n++;
            if (n == 101) chk("t1_clear_q", bus.cpu_q, 8'hFF);
        end while (bus.clr_busy && n < 400);
        chk("t1_sweep_len", n, 256);
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'hFF;
        for (int i = 0; i < 256; i++) rd(8'(i), exp_mem[i]);

        // 2: write then read; read-during-write returns the old value
        bus.cpu_ad = 8'h40; bus.cpu_din = 8'h12; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
        sb.push_back(exp_mem[8'h40]);
        step();
        chk("t2_rdw_old", bus.cpu_q, sb.pop_front());
        exp_mem[8'h40] = 8'h12;
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
        rd(8'h40, exp_mem[8'h40]);

        // 3: CPU busy every cycle, loader fills FIFO, 5th byte waits, drain when CPU idles
        for (int k = 0; k < 4; k++) begin
            bus.cpu_ad = 8'(8'h80 + k); bus.cpu_din = 8'(8'h60 + k);
            bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
            push_byte(8'(8'h20 + k), 8'(8'h30 + k));
            step();
            exp_mem[8'h80 + k] = 8'(8'h60 + k);
            chk($sformatf("t3_wait_push%0d", k + 1), bus.tape_wait, (k == 3) ? 1 : 0);
        end
        bus.tape_wr = 1'b0;
        for (int k = 4; k < 6; k++) begin
            bus.cpu_ad = 8'(8'h80 + k); bus.cpu_din = 8'(8'h60 + k);
            step();
            exp_mem[8'h80 + k] = 8'(8'h60 + k);
            chk($sformatf("t3_wait_hold%0d", k), bus.tape_wait, 1'b1);
        end
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
        push_byte(8'h24, 8'h34);
        #1;
        chk("t3_wait_pop_frees", bus.tape_wait, 1'b0);
        step();
        bus.tape_wr = 1'b0;
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 5; k++) exp_mem[8'h20 + k] = 8'(8'h30 + k);
        for (int k = 0; k < 5; k++) rd(8'(8'h20 + k), exp_mem[8'h20 + k]);
        for (int k = 0; k < 6; k++) rd(8'(8'h80 + k), exp_mem[8'h80 + k]);

        // 4: CPU 0xAA and queued loader 0x55 to the same address; loader wins
        bus.cpu_ad = 8'h10; bus.cpu_din = 8'hAA; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
        push_byte(8'h10, 8'h55);
        step();
        bus.tape_wr = 1'b0;
        rd(8'h10, 8'hAA);
        exp_mem[8'h10] = 8'h55;
        rd(8'h10, exp_mem[8'h10]);
        chk("t4_csum", bus.tape_csum, exp_cs(8'h4F));
        chk("t4_load_done", bus.load_done, 1'b0);

        // 5: fresh reset, three bytes plus complete, load_done one cycle after last commit
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_sweep("t5_sweep_len");
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'hFF;
        rd(8'h40, exp_mem[8'h40]);
        push_byte(8'h50, 8'h01);
        step();
        push_byte(8'h51, 8'h02);
        step();
        push_byte(8'h52, 8'h03);
        bus.tape_complete = 1'b1;
        step();
        bus.tape_wr = 1'b0;
        bus.tape_complete = 1'b0;
        chk("t5_done_pending", bus.load_done, 1'b0);
        step();
        chk("t5_done_last_commit", bus.load_done, 1'b0);
        chk("t5_csum", bus.tape_csum, exp_cs(8'h06));
        step();
        chk("t5_done_set", bus.load_done, 1'b1);
        push_byte(8'h53, 8'h04);
        step();
        bus.tape_wr = 1'b0;
        step();
        chk("t5_done_sticky", bus.load_done, 1'b1);
        chk("t5_csum_after", bus.tape_csum, exp_cs(8'h0A));
        for (int k = 0; k < 4; k++) exp_mem[8'h50 + k] = 8'(k + 1);
        for (int k = 0; k < 4; k++) rd(8'(8'h50 + k), exp_mem[8'h50 + k]);

        // 6: reset mid-load, then again mid-sweep; FIFO flushed and sweep restarts
        bus.cpu_ad = 8'h90; bus.cpu_din = 8'h11; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
        push_byte(8'h60, 8'h77);
        step();
        push_byte(8'h61, 8'h77);
        step();
        bus.tape_wr = 1'b0;
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
        reset = 1'b1;
        step();
        reset_values("t6_reset_load");
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k == 20) push_byte(8'h70, 8'h99);
            else bus.tape_wr = 1'b0;
            step();
        end
        bus.tape_wr = 1'b0;
        chk("t6_mid_sweep_busy", bus.clr_busy, 1'b1);
        reset = 1'b1;
        step();
        reset_values("t6_reset_sweep");
        reset = 1'b0;
        n = 0;
        do begin
            if (n >= 10 && n < 14) push_byte(8'(8'h71 + n - 10), 8'(8'h41 + n - 10));
            else bus.tape_wr = 1'b0;
            bus.tape_complete = (n == 20);
            step();
            n++;
            if (n == 14) chk("t6_wait_in_clear", bus.tape_wait, 1'b1);
        end while (bus.clr_busy && n < 400);
        chk("t6_sweep_len", n, 256);
        bus.tape_wr = 1'b0;
        bus.tape_complete = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t6_done_pending", bus.load_done, 1'b0);
        step();
        chk("t6_done_set", bus.load_done, 1'b1);
        chk("t6_csum", bus.tape_csum, exp_cs(8'h0A));
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'hFF;
        for (int k = 0; k < 4; k++) exp_mem[8'h71 + k] = 8'(8'h41 + k);
        for (int i = 0; i < 256; i++) rd(8'(i), exp_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
